// File: rtl/metro_validator_arbiter.sv
// ============================================================================
// Module      : metro_validator_arbiter
// Description : Round-robin sharing of one fare validator among N_LANES
//               turnstile lanes: grant, timed card read, balance check,
//               then a timed gate-open window or a deny.
//               Optional METRO_ARB_STATS_EN adds saturating pass/deny counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module metro_validator_arbiter #(
    parameter int unsigned N_LANES     = 4,
    parameter int unsigned BAL_W       = 3,
    parameter int unsigned FARE        = 1,
    parameter int unsigned READ_CYCLES = 2,
    parameter int unsigned OPEN_CYCLES = 4
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [N_LANES-1:0]           lane_req,
    input  logic [N_LANES*BAL_W-1:0]     lane_balance,
    output logic [N_LANES-1:0]           lane_grant,
    output logic [N_LANES-1:0]           gate_open,
    output logic                         done,
    output logic [$clog2(N_LANES)-1:0]   done_lane,
    output logic                         ok,
    output logic [BAL_W-1:0]             rem_balance,
    output logic                         busy
`ifdef METRO_ARB_STATS_EN
    ,
    output logic [7:0]                   pass_cnt,
    output logic [7:0]                   deny_cnt
`endif
);

    localparam int unsigned IDX_W   = $clog2(N_LANES);
    localparam int unsigned CNT_MAX = (READ_CYCLES > OPEN_CYCLES) ? READ_CYCLES : OPEN_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] READ_LAST = CNT_W'(READ_CYCLES - 1);
    localparam logic [CNT_W-1:0] OPEN_LAST = CNT_W'(OPEN_CYCLES - 1);
    localparam logic [BAL_W-1:0] FARE_V    = BAL_W'(FARE);
    localparam logic [IDX_W:0]   N_EXT     = (IDX_W + 1)'(N_LANES);
    localparam logic [IDX_W-1:0] LAST_LANE = IDX_W'(N_LANES - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_READ  = 3'd1;
    localparam logic [2:0] S_CHECK = 3'd2;
    localparam logic [2:0] S_OPEN  = 3'd3;
    localparam logic [2:0] S_DENY  = 3'd4;

    logic [2:0]         state_q,     state_d;
    logic [IDX_W-1:0]   rr_ptr_q,    rr_ptr_d;
    logic [IDX_W-1:0]   winner_q,    winner_d;
    logic [CNT_W-1:0]   cnt_q,       cnt_d;
    logic [BAL_W-1:0]   bal_q,       bal_d;
    logic [N_LANES-1:0] grant_q,     grant_d;
    logic [N_LANES-1:0] gate_q,      gate_d;
    logic               done_q,      done_d;
    logic [IDX_W-1:0]   done_lane_q, done_lane_d;
    logic               ok_q,        ok_d;
    logic [BAL_W-1:0]   rem_q,       rem_d;

    logic               arb_found;
    logic [IDX_W-1:0]   arb_winner;
    logic [IDX_W:0]     arb_sum;
    logic [IDX_W-1:0]   next_ptr;
    logic [BAL_W-1:0]   sel_bal;
    logic               fare_ok;

    // First requester at or after rr_ptr, wrapping; rr_ptr + k stays below 2*N_LANES.
    always_comb begin
        arb_found  = 1'b0;
        arb_winner = '0;
        arb_sum    = '0;
        for (int k = 0; k < int'(N_LANES); k++) begin
            arb_sum = {1'b0, rr_ptr_q} + (IDX_W + 1)'(k);
            if (arb_sum >= N_EXT) begin
                arb_sum = arb_sum - N_EXT;
            end
            if (!arb_found && lane_req[arb_sum[IDX_W-1:0]]) begin
                arb_found  = 1'b1;
                arb_winner = arb_sum[IDX_W-1:0];
            end
        end
    end

    assign next_ptr = (winner_q == LAST_LANE) ? '0 : winner_q + IDX_W'(1);
    assign sel_bal  = lane_balance[winner_q*BAL_W +: BAL_W];
    assign fare_ok  = (bal_q >= FARE_V);

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        winner_d    = winner_q;
        cnt_d       = cnt_q;
        bal_d       = bal_q;
        grant_d     = grant_q;
        gate_d      = gate_q;
        done_d      = 1'b0;
        done_lane_d = done_lane_q;
        ok_d        = ok_q;
        rem_d       = rem_q;

        case (state_q)
            S_IDLE: begin
                if (arb_found) begin
                    state_d  = S_READ;
                    winner_d = arb_winner;
                    grant_d  = N_LANES'(1) << arb_winner;
                    cnt_d    = '0;
                end
            end
            S_READ: begin
                // A lane withdrawing its card mid-read abandons the transaction silently.
                if (!lane_req[winner_q]) begin
                    state_d  = S_IDLE;
                    grant_d  = '0;
                    rr_ptr_d = next_ptr;
                end else if (cnt_q == READ_LAST) begin
                    state_d = S_CHECK;
                    bal_d   = sel_bal;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_CHECK: begin
                done_d      = 1'b1;
                done_lane_d = winner_q;
                cnt_d       = '0;
                if (fare_ok) begin
                    state_d = S_OPEN;
                    ok_d    = 1'b1;
                    rem_d   = bal_q - FARE_V;
                    gate_d  = grant_q;
                end else begin
                    state_d = S_DENY;
                    ok_d    = 1'b0;
                    rem_d   = bal_q;
                end
            end
            S_OPEN: begin
                if (cnt_q == OPEN_LAST) begin
                    state_d  = S_IDLE;
                    grant_d  = '0;
                    gate_d   = '0;
                    rr_ptr_d = next_ptr;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DENY: begin
                state_d  = S_IDLE;
                grant_d  = '0;
                rr_ptr_d = next_ptr;
            end
            default: begin
                state_d = S_IDLE;
                grant_d = '0;
                gate_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            rr_ptr_q    <= '0;
            winner_q    <= '0;
            cnt_q       <= '0;
            bal_q       <= '0;
            grant_q     <= '0;
            gate_q      <= '0;
            done_q      <= 1'b0;
            done_lane_q <= '0;
            ok_q        <= 1'b0;
            rem_q       <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            winner_q    <= winner_d;
            cnt_q       <= cnt_d;
            bal_q       <= bal_d;
            grant_q     <= grant_d;
            gate_q      <= gate_d;
            done_q      <= done_d;
            done_lane_q <= done_lane_d;
            ok_q        <= ok_d;
            rem_q       <= rem_d;
        end
    end

    assign lane_grant  = grant_q;
    assign gate_open   = gate_q;
    assign done        = done_q;
    assign done_lane   = done_lane_q;
    assign ok          = ok_q;
    assign rem_balance = rem_q;
    assign busy        = (state_q != S_IDLE);

`ifdef METRO_ARB_STATS_EN
    logic [7:0] pass_cnt_q, pass_cnt_d;
    logic [7:0] deny_cnt_q, deny_cnt_d;

    // Counted at the CHECK edge, i.e. together with the done pulse it produces.
    always_comb begin
        pass_cnt_d = pass_cnt_q;
        deny_cnt_d = deny_cnt_q;
        if (state_q == S_CHECK) begin
            if (fare_ok) begin
                if (pass_cnt_q != 8'hFF) pass_cnt_d = pass_cnt_q + 8'd1;
            end else begin
                if (deny_cnt_q != 8'hFF) deny_cnt_d = deny_cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pass_cnt_q <= 8'd0;
            deny_cnt_q <= 8'd0;
        end else begin
            pass_cnt_q <= pass_cnt_d;
            deny_cnt_q <= deny_cnt_d;
        end
    end

    assign pass_cnt = pass_cnt_q;
    assign deny_cnt = deny_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_metro_validator_arbiter.sv
// ============================================================================
// Module      : tb_metro_validator_arbiter
// Description : Scoreboard bench for metro_validator_arbiter (default params).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_metro_validator_arbiter;

    localparam int N    = 4;
    localparam int BW   = 3;
    localparam int FARE = 1;

    logic            clk = 1'b0;
    logic            reset_n;
    logic [N-1:0]    lane_req;
    logic [N*BW-1:0] lane_balance;
    logic [N-1:0]    lane_grant;
    logic [N-1:0]    gate_open;
    logic            done;
    logic [1:0]      done_lane;
    logic            ok;
    logic [BW-1:0]   rem_balance;
    logic            busy;
`ifdef METRO_ARB_STATS_EN
    logic [7:0]      pass_cnt;
    logic [7:0]      deny_cnt;
`endif

    always #5 clk = ~clk;

    metro_validator_arbiter #(
        .N_LANES(N), .BAL_W(BW), .FARE(FARE), .READ_CYCLES(2), .OPEN_CYCLES(4)
    ) dut (
        .clk(clk), .reset_n(reset_n), .lane_req(lane_req), .lane_balance(lane_balance),
        .lane_grant(lane_grant), .gate_open(gate_open), .done(done), .done_lane(done_lane),
        .ok(ok), .rem_balance(rem_balance), .busy(busy)
`ifdef METRO_ARB_STATS_EN
        , .pass_cnt(pass_cnt), .deny_cnt(deny_cnt)
`endif
    );

    typedef struct packed {
        logic [1:0]    lane;
        logic          ok;
        logic [BW-1:0] rem;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    function automatic exp_t model(input int lane, input int bal);
        exp_t e;
        e.lane = 2'(lane);
        if (bal >= FARE) begin
            e.ok  = 1'b1;
            e.rem = BW'(bal - FARE);
        end else begin
            e.ok  = 1'b0;
            e.rem = BW'(bal);
        end
        return e;
    endfunction

    task automatic apply_reset;
        reset_n      = 1'b0;
        lane_req     = '0;
        lane_balance = '0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic set_bal(input int lane, input int bal);
        lane_balance[lane*BW +: BW] = BW'(bal);
    endtask

    task automatic test_reset;
        reset_n      = 1'b0;
        lane_req     = 4'b1111;
        lane_balance = '1;
        @(negedge clk);
        n_checks++;
        if ({lane_grant, gate_open, done, done_lane, ok, rem_balance, busy} !== 16'h0)
            $display("FAIL reset_outputs: got %h want 0000",
                     {lane_grant, gate_open, done, done_lane, ok, rem_balance, busy});
        else n_pass++;
        repeat (2) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || lane_grant !== 4'b0000)
            $display("FAIL reset_hold: busy=%b grant=%b want 0/0000", busy, lane_grant);
        else n_pass++;
        lane_req = '0;
        reset_n  = 1'b1;
    endtask

    task automatic test_single;
        int   done_cyc;
        int   n_done;
        int   gate_cyc;
        bit   bad_gate;
        exp_t e;
        apply_reset();
        set_bal(0, 3);
        lane_req = 4'b0001;
        sb.push_back(model(0, 3));
        done_cyc = -1; n_done = 0; gate_cyc = 0; bad_gate = 0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (c == 1) begin
                n_checks++;
                if (lane_grant !== 4'b0001) $display("FAIL single_grant: got %b want 0001", lane_grant);
                else n_pass++;
            end
            if (gate_open !== 4'b0000) begin
                gate_cyc++;
                if (gate_open !== 4'b0001) bad_gate = 1;
            end
            if (done === 1'b1) begin
                n_done++;
                done_cyc = c;
                lane_req = '0;
                n_checks++;
                if (sb.size() == 0) $display("FAIL single_result: unexpected done lane=%0d", done_lane);
                else begin
                    e = sb.pop_front();
                    if ({done_lane, ok, rem_balance} !== e)
                        $display("FAIL single_result: got lane=%0d ok=%b rem=%0d want lane=%0d ok=%b rem=%0d",
                                 done_lane, ok, rem_balance, e.lane, e.ok, e.rem);
                    else n_pass++;
                end
            end
        end
        n_checks++;
        if (done_cyc != 4 || n_done != 1)
            $display("FAIL single_latency: done at cycle %0d (%0d pulses) want cycle 4 (1 pulse)", done_cyc, n_done);
        else n_pass++;
        n_checks++;
        if (gate_cyc != 4 || bad_gate) $display("FAIL single_gate: %0d open cycles bad=%0d want 4 bad=0", gate_cyc, bad_gate);
        else n_pass++;
        n_checks++;
        if (busy !== 1'b0 || lane_grant !== 4'b0000) $display("FAIL single_idle: busy=%b grant=%b want 0/0000", busy, lane_grant);
        else n_pass++;
`ifdef METRO_ARB_STATS_EN
        n_checks++;
        if (pass_cnt !== 8'd1 || deny_cnt !== 8'd0) $display("FAIL single_stats: pass=%0d deny=%0d want 1/0", pass_cnt, deny_cnt);
        else n_pass++;
`endif
    endtask

    task automatic test_deny;
        int   done_cyc;
        int   gate_cyc;
        exp_t e;
        set_bal(2, 0);
        lane_req = 4'b0100;
        sb.push_back(model(2, 0));
        done_cyc = -1; gate_cyc = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (gate_open !== 4'b0000) gate_cyc++;
            if (done_cyc > 0 && c == done_cyc + 1) begin
                n_checks++;
                if (busy !== 1'b0) $display("FAIL deny_idle: busy=%b want 0 one cycle after done", busy);
                else n_pass++;
            end
            if (done === 1'b1) begin
                done_cyc = c;
                lane_req = '0;
                n_checks++;
                if (sb.size() == 0) $display("FAIL deny_result: unexpected done lane=%0d", done_lane);
                else begin
                    e = sb.pop_front();
                    if ({done_lane, ok, rem_balance} !== e)
                        $display("FAIL deny_result: got lane=%0d ok=%b rem=%0d want lane=%0d ok=%b rem=%0d",
                                 done_lane, ok, rem_balance, e.lane, e.ok, e.rem);
                    else n_pass++;
                end
            end
        end
        n_checks++;
        if (done_cyc != 4 || gate_cyc != 0)
            $display("FAIL deny_timing: done cycle %0d gate cycles %0d want 4/0", done_cyc, gate_cyc);
        else n_pass++;
    endtask

    task automatic test_boundary;
        int   n_done;
        exp_t e;
        exp_t last;
        set_bal(1, FARE);
        lane_req = 4'b0010;
        sb.push_back(model(1, FARE));
        n_done = 0; last = '0;
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                n_done++;
                lane_req = '0;
                n_checks++;
                if (sb.size() == 0) $display("FAIL boundary_result: unexpected done lane=%0d", done_lane);
                else begin
                    e = sb.pop_front();
                    last = e;
                    if ({done_lane, ok, rem_balance} !== e)
                        $display("FAIL boundary_result: got lane=%0d ok=%b rem=%0d want lane=%0d ok=%b rem=%0d",
                                 done_lane, ok, rem_balance, e.lane, e.ok, e.rem);
                    else n_pass++;
                end
            end
        end
        n_checks++;
        if (n_done != 1 || {done_lane, ok, rem_balance} !== last)
            $display("FAIL boundary_hold: %0d dones, held lane=%0d ok=%b rem=%0d want 1 done, lane=%0d ok=%b rem=%0d",
                     n_done, done_lane, ok, rem_balance, last.lane, last.ok, last.rem);
        else n_pass++;
    endtask

    task automatic test_round_robin;
        int   n_done;
        int   gate_cyc;
        bit   overlap;
        exp_t e;
        apply_reset();
        for (int i = 0; i < N; i++) set_bal(i, 5);
        lane_req = 4'b1111;
        sb.push_back(model(0, 5));
        sb.push_back(model(1, 5));
        sb.push_back(model(2, 5));
        sb.push_back(model(3, 5));
        sb.push_back(model(0, 5));
        n_done = 0; gate_cyc = 0; overlap = 0;
        for (int c = 1; c <= 120; c++) begin
            @(negedge clk);
            if (gate_open !== 4'b0000) begin
                gate_cyc++;
                if ($countones(gate_open) != 1 || gate_open !== lane_grant) overlap = 1;
            end
            if (done === 1'b1) begin
                n_done++;
                if (n_done == 5) lane_req = '0;
                n_checks++;
                if (sb.size() == 0) $display("FAIL rr_result: unexpected done lane=%0d", done_lane);
                else begin
                    e = sb.pop_front();
                    if ({done_lane, ok, rem_balance} !== e)
                        $display("FAIL rr_result: done #%0d got lane=%0d ok=%b rem=%0d want lane=%0d ok=%b rem=%0d",
                                 n_done, done_lane, ok, rem_balance, e.lane, e.ok, e.rem);
                    else n_pass++;
                end
            end
            if (n_done >= 5 && busy === 1'b0) break;
        end
        n_checks++;
        if (n_done != 5 || busy !== 1'b0) $display("FAIL rr_complete: %0d dones busy=%b want 5 dones busy=0", n_done, busy);
        else n_pass++;
        n_checks++;
        if (gate_cyc != 20 || overlap) $display("FAIL rr_gate: %0d open cycles overlap=%0d want 20/0", gate_cyc, overlap);
        else n_pass++;
        sb.delete();
    endtask

    task automatic test_abort;
        int   n_done;
        bit   gate1;
        exp_t e;
        apply_reset();
        set_bal(0, 2);
        set_bal(1, 4);
        set_bal(3, 6);
        lane_req = 4'b1010;
        sb.push_back(model(3, 6));
        sb.push_back(model(0, 2));
        n_done = 0; gate1 = 0;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (gate_open[1] === 1'b1) gate1 = 1;
            if (c == 1) begin
                n_checks++;
                if (lane_grant !== 4'b0010) $display("FAIL abort_grant1: got %b want 0010", lane_grant);
                else n_pass++;
                lane_req[0] = 1'b1;
            end
            if (c == 2) lane_req[1] = 1'b0;
            if (c == 3) begin
                n_checks++;
                if (busy !== 1'b0 || lane_grant !== 4'b0000 || done !== 1'b0)
                    $display("FAIL abort_idle: busy=%b grant=%b done=%b want 0/0000/0", busy, lane_grant, done);
                else n_pass++;
            end
            if (c == 4) begin
                n_checks++;
                if (lane_grant !== 4'b1000) $display("FAIL abort_next_grant: got %b want 1000", lane_grant);
                else n_pass++;
            end
            if (done === 1'b1) begin
                n_done++;
                lane_req[done_lane] = 1'b0;
                n_checks++;
                if (sb.size() == 0) $display("FAIL abort_result: unexpected done lane=%0d", done_lane);
                else begin
                    e = sb.pop_front();
                    if ({done_lane, ok, rem_balance} !== e)
                        $display("FAIL abort_result: got lane=%0d ok=%b rem=%0d want lane=%0d ok=%b rem=%0d",
                                 done_lane, ok, rem_balance, e.lane, e.ok, e.rem);
                    else n_pass++;
                end
            end
            if (n_done >= 2 && busy === 1'b0) break;
        end
        n_checks++;
        if (n_done != 2 || gate1) $display("FAIL abort_summary: %0d dones gate1=%0d want 2/0", n_done, gate1);
        else n_pass++;
        sb.delete();
    endtask

    task automatic test_reset_mid_open;
        bit   got;
        exp_t e;
        apply_reset();
        set_bal(0, 3);
        lane_req = 4'b0001;
        sb.push_back(model(0, 3));
        got = 0;
        for (int c = 1; c <= 20 && !got; c++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                got = 1;
                n_checks++;
                e = sb.pop_front();
                if ({done_lane, ok, rem_balance} !== e)
                    $display("FAIL midreset_result: got lane=%0d ok=%b rem=%0d want lane=%0d ok=%b rem=%0d",
                             done_lane, ok, rem_balance, e.lane, e.ok, e.rem);
                else n_pass++;
            end
        end
        n_checks++;
        if (!got) $display("FAIL midreset_timeout: no done within 20 cycles, want done");
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (gate_open !== 4'b0001) $display("FAIL midreset_gate: got %b want 0001 in 2nd open cycle", gate_open);
        else n_pass++;
        reset_n = 1'b0;
        #1;
        n_checks++;
        if ({lane_grant, gate_open, done, done_lane, ok, rem_balance, busy} !== 16'h0)
            $display("FAIL midreset_outputs: got %h want 0000",
                     {lane_grant, gate_open, done, done_lane, ok, rem_balance, busy});
        else n_pass++;
`ifdef METRO_ARB_STATS_EN
        n_checks++;
        if (pass_cnt !== 8'd0 || deny_cnt !== 8'd0) $display("FAIL midreset_stats: pass=%0d deny=%0d want 0/0", pass_cnt, deny_cnt);
        else n_pass++;
`endif
        lane_req = '0;
        @(negedge clk);
        reset_n = 1'b1;
        sb.delete();
    endtask

    initial begin
        reset_n      = 1'b0;
        lane_req     = '0;
        lane_balance = '0;
        test_reset();
        test_single();
        test_deny();
        test_boundary();
        test_round_robin();
        test_abort();
        test_reset_mid_open();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want normal completion");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
